// File: rtl/time_mode_controller.sv
// Purpose: button front-end for a watch/stopwatch; stopwatch run/clear FSM, field pointer, edit commands with auto-repeat.
// Latency: every output is registered; a button edge sampled on one rising edge is visible for the following cycle.
// Backpressure: none; commands are single-cycle pulses and the consumer must accept them when issued.
module time_mode_controller #(
    parameter int CLK_HZ    = 100_000_000,
    parameter int HOLD_MS   = 500,
    parameter int REPEAT_MS = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_up,
    input  logic       i_down,
    input  logic       i_left,
    input  logic       i_right,
    input  logic       i_watch_select,
    input  logic       i_edit,
    output logic       o_run_stop,
    output logic       o_clear,
    output logic [1:0] o_edit_msec,
    output logic [1:0] o_edit_sec,
    output logic [1:0] o_edit_min,
    output logic [1:0] o_edit_hour,
    output logic [3:0] o_led
);

    localparam int HOLD_CYC = CLK_HZ / 1000 * HOLD_MS;
    localparam int REP_CYC  = CLK_HZ / 1000 * REPEAT_MS;
    localparam int MAX_CYC  = (HOLD_CYC > REP_CYC) ? HOLD_CYC : REP_CYC;
    localparam int CW       = (MAX_CYC > 0) ? $clog2(MAX_CYC + 1) : 1;
    localparam logic [CW-1:0] HOLD_T = CW'(HOLD_CYC);
    localparam logic [CW-1:0] REP_T  = CW'(REP_CYC);

    typedef enum logic [1:0] {SW_STOP, SW_RUN, SW_CLEAR} sw_state_t;

    sw_state_t       sw_state_q, sw_state_d;
    logic            run_q, run_d;
    logic            clr_q, clr_d;
    logic            up_prev_q, down_prev_q, left_prev_q, right_prev_q;
    logic [1:0]      ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            rep_q, rep_d;
    logic [1:0]      edit_msec_q, edit_sec_q, edit_min_q, edit_hour_q;
    logic [1:0]      edit_msec_d, edit_sec_d, edit_min_d, edit_hour_d;
    logic [3:0]      led_q, led_d;

    logic            press_up, press_down, press_left, press_right;
    logic            sw_left, sw_right, ptr_inc, ptr_dec;
    logic            edit_act, single_held, start, fire;
    logic [CW-1:0]   target;
    logic [1:0]      cmd;

    // Edge detection, stopwatch next state, pointer and repeat-counter next state
    always_comb begin
        press_up    = i_up    & ~up_prev_q;
        press_down  = i_down  & ~down_prev_q;
        press_left  = i_left  & ~left_prev_q;
        press_right = i_right & ~right_prev_q;

        // Left and right rising together cancel each other everywhere
        sw_left  = i_watch_select & press_left  & ~press_right;
        sw_right = i_watch_select & press_right & ~press_left;

        sw_state_d = sw_state_q;
        case (sw_state_q)
            SW_STOP: begin
                if (sw_right)     sw_state_d = SW_RUN;
                else if (sw_left) sw_state_d = SW_CLEAR;
            end
            SW_RUN: begin
                if (sw_right)     sw_state_d = SW_STOP;
            end
            default:              sw_state_d = SW_STOP;
        endcase
        run_d = (sw_state_d == SW_RUN);
        clr_d = (sw_state_d == SW_CLEAR);

        edit_act = ~i_watch_select & i_edit;
        ptr_inc  = edit_act & press_left  & ~press_right;
        ptr_dec  = edit_act & press_right & ~press_left;
        ptr_d    = ptr_q;
        if (ptr_inc)      ptr_d = ptr_q + 2'd1;
        else if (ptr_dec) ptr_d = ptr_q - 2'd1;

        // Repeats only run from a fresh press of exactly one of up/down;
        // cnt_q == 0 means idle, so a second button joining kills the sequence.
        single_held = i_up ^ i_down;
        start  = edit_act & ((press_up & ~i_down) | (press_down & ~i_up));
        target = rep_q ? REP_T : HOLD_T;
        fire   = 1'b0;
        cnt_d  = '0;
        rep_d  = 1'b0;
        if (start) begin
            fire  = 1'b1;
            cnt_d = CW'(1);
        end else if (edit_act && single_held && (cnt_q != '0)) begin
            if (cnt_q == target) begin
                fire  = 1'b1;
                cnt_d = CW'(1);
                rep_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
                rep_d = rep_q;
            end
        end

        // Whenever fire is set exactly one of up/down is high
        cmd         = i_up ? 2'b01 : 2'b11;
        edit_msec_d = (fire && ptr_q == 2'd0) ? cmd : 2'b00;
        edit_sec_d  = (fire && ptr_q == 2'd1) ? cmd : 2'b00;
        edit_min_d  = (fire && ptr_q == 2'd2) ? cmd : 2'b00;
        edit_hour_d = (fire && ptr_q == 2'd3) ? cmd : 2'b00;

        if (i_watch_select) led_d = {3'b100, run_d};
        else if (i_edit)    led_d = 4'b0001 << ptr_d;
        else                led_d = 4'b0000;
    end

    // Stopwatch FSM with its registered run/clear outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_state_q <= SW_STOP;
            run_q      <= 1'b0;
            clr_q      <= 1'b0;
        end else begin
            sw_state_q <= sw_state_d;
            run_q      <= run_d;
            clr_q      <= clr_d;
        end
    end

    // Button history, field pointer and auto-repeat counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            up_prev_q    <= 1'b0;
            down_prev_q  <= 1'b0;
            left_prev_q  <= 1'b0;
            right_prev_q <= 1'b0;
            ptr_q        <= 2'd1;
            cnt_q        <= '0;
            rep_q        <= 1'b0;
        end else begin
            up_prev_q    <= i_up;
            down_prev_q  <= i_down;
            left_prev_q  <= i_left;
            right_prev_q <= i_right;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            rep_q        <= rep_d;
        end
    end

    // Registered edit command pulses and LED indicator
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            edit_msec_q <= 2'b00;
            edit_sec_q  <= 2'b00;
            edit_min_q  <= 2'b00;
            edit_hour_q <= 2'b00;
            led_q       <= 4'b0000;
        end else begin
            edit_msec_q <= edit_msec_d;
            edit_sec_q  <= edit_sec_d;
            edit_min_q  <= edit_min_d;
            edit_hour_q <= edit_hour_d;
            led_q       <= led_d;
        end
    end

    assign o_run_stop  = run_q;
    assign o_clear     = clr_q;
    assign o_edit_msec = edit_msec_q;
    assign o_edit_sec  = edit_sec_q;
    assign o_edit_min  = edit_min_q;
    assign o_edit_hour = edit_hour_q;
    assign o_led       = led_q;

endmodule

// File: doc/time_mode_controller.md
TIME_MODE_CONTROLLER -- requirements
Module: time_mode_controller

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 100_000_000, clock frequency in Hz.
REQ-002 The block SHALL have parameter HOLD_MS, default 500, press-and-hold delay before auto-repeat starts.
REQ-003 The block SHALL have parameter REPEAT_MS, default 100, auto-repeat period.
REQ-004 The block SHALL have port clk  input  1  system clock; all state changes on the rising edge.
REQ-005 The block SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-006 The block SHALL have ports i_up, i_down, i_left, i_right  input  1 each  debounced button levels, high = pressed.
REQ-007 The block SHALL have port i_watch_select  input  1  0 = watch mode, 1 = stopwatch mode.
REQ-008 The block SHALL have port i_edit  input  1  watch edit enable.
REQ-009 The block SHALL have port o_run_stop  output  1  stopwatch run (1) or stop (0).
REQ-010 The block SHALL have port o_clear  output  1  one-cycle stopwatch clear pulse.
REQ-011 The block SHALL have ports o_edit_msec, o_edit_sec, o_edit_min, o_edit_hour  output  2 each  edit command: 00 none, 01 increment, 11 decrement.
REQ-012 The block SHALL have port o_led  output  4  mode and field indicator.

Function
REQ-013 The block SHALL derive HOLD_CYC = CLK_HZ/1000*HOLD_MS and REP_CYC = CLK_HZ/1000*REPEAT_MS, sizing its counters with $clog2.
REQ-014 The block SHALL register each button every clock; a press is sampled high while the previous sample is low, and produces a registered output visible for exactly the cycle after that edge.
REQ-015 The block SHALL run the stopwatch FSM with states STOP, RUN and CLEAR; o_run_stop = 1 only in RUN, and o_clear = 1 only in CLEAR.
REQ-016 The block SHALL process stopwatch presses only when i_watch_select = 1: i_right press toggles STOP and RUN; i_left press in STOP goes to CLEAR, which returns to STOP on the next clock; i_left press in RUN is ignored.
REQ-017 The block SHALL retain the stopwatch FSM state when i_watch_select changes, and a CLEAR in progress SHALL always complete.
REQ-018 The block SHALL keep a 2-bit field pointer: 0 msec, 1 sec, 2 min, 3 hour.
REQ-019 The pointer SHALL change only while i_watch_select = 0 and i_edit = 1: i_left press increments it (3 wraps to 0), and i_right press decrements it (0 wraps to 3).
REQ-020 The block SHALL treat simultaneous i_left and i_right presses in the same cycle as no action.
REQ-021 In edit mode, an i_up press SHALL drive 01 and an i_down press SHALL drive 11 on the selected field's o_edit_* for one cycle; all other fields SHALL stay 00.
REQ-022 The block SHALL treat simultaneous i_up and i_down presses as no action, and SHALL issue no repeats while both buttons are held.
REQ-023 Auto-repeat: while the same button stays high, a further one-cycle pulse SHALL occur HOLD_CYC cycles after the initial pulse, then every REP_CYC cycles.
REQ-024 Releasing the button, leaving edit mode, or i_watch_select = 1 SHALL clear the repeat counter at once.
REQ-025 A pointer change while i_up or i_down is held SHALL move subsequent repeat pulses to the new field.
REQ-026 Outside edit mode, all o_edit_* SHALL be 00 and the pointer SHALL be held.
REQ-027 o_led SHALL be 4'b1000 | {3'b000, o_run_stop} in stopwatch mode.
REQ-028 o_led SHALL be the one-hot of the pointer (bit0 msec to bit3 hour) in watch edit mode.
REQ-029 o_led SHALL be 4'b0000 in watch non-edit mode.
REQ-030 All outputs SHALL be registered, with no combinational path from input to output.

Reset
REQ-031 On reset the block SHALL set the FSM to STOP, o_run_stop 0, o_clear 0, pointer 1 (sec), all o_edit_* 00, button history registers 0, and repeat counter 0.
REQ-032 o_led after reset SHALL follow REQ-027 to REQ-029 from the current inputs on the first clock.
REQ-033 Reset asserted mid-hold or mid-CLEAR SHALL abort the operation, and no pulse SHALL be emitted after release.
REQ-034 A button already high when reset deasserts SHALL count as a press on the first clock.

Verification (bench CLK_HZ=1000, so HOLD_CYC=500, REP_CYC=100)
REQ-035 Stopwatch start/stop: select=1, then i_right pulse, then i_right pulse -> o_run_stop goes 0->1->0 and o_led goes 1000->1001->1000.
REQ-036 Stopwatch clear: select=1 in STOP, i_left press -> o_clear high for exactly 1 cycle; i_left pressed in RUN -> o_clear stays 0.
REQ-037 Field wrap: select=0, edit=1 after reset, then 3 i_left presses -> pointer 1->2->3->0 and o_led shows 0010, 0100, 1000, 0001; one i_right press then returns the pointer to 3.
REQ-038 Auto-repeat: pointer = sec, i_up held 800 cycles -> o_edit_sec=01 pulses at cycle offsets 0, 500, 600, 700 (4 pulses total), and the other fields stay 00.
REQ-039 Conflicts: i_up and i_down rising in the same cycle, and i_left and i_right rising in the same cycle -> no edit pulses and no pointer change.
REQ-040 Reset mid-hold: i_down held 300 cycles, reset pulsed, i_down released -> no further pulses, and pointer = 1.
